mnist_infer_ctrl: RTL and testbench
===================================

# mnist_infer_ctrl

Top-level sequencer for the MNIST accelerator's inference pass. On a start request it restarts the row-serial image reader, waits for its image-ready flag, then schedules ten class-score computations on the shared scorer datapath over a req/ack handshake. It tracks the running argmax and reports the winning digit, with a timeout per phase. It sits between the host/pin interface and the reader/scorer datapath.

## Interface
Parameters:
- `SCORE_W`, 12: width of the signed two's-complement class score.
- `NUM_CLASSES`, 10: number of classes scheduled; the digit index range is 0..NUM_CLASSES-1.
- `TIMEOUT`, 64: maximum cycles spent in LOAD or REQ before the controller aborts.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE.
- `rd_reset_n`  out  1  active-low restart for the image reader. Reset value 1.
- `image_ready`  in  1  reader flag; level, held until the next reader restart.
- `class_req`  out  1  score request to the scorer. Reset value 0.
- `class_idx`  out  4  class being scored; valid while `class_req`=1. Reset value 0.
- `class_ack`  in  1  scorer completion; `class_score` is valid in the same cycle.
- `class_score`  in  SCORE_W  signed score.
- `digit`  out  4  winning class; held until the next accepted start. Reset value 0.
- `digit_valid`  out  1  one-cycle pulse when `digit` updates. Reset value 0.
- `busy`  out  1  high in every state except IDLE. Reset value 0.
- `error`  out  1  sticky timeout flag; cleared by the next accepted start. Reset value 0.

## Operation
States:
- **IDLE**
  - If `start`=1: go to ARM, clear `error`, clear `class_idx`.
  - `start` is ignored in every other state. There is no queuing.
- **ARM**
  - Drive `rd_reset_n`=0 for exactly one cycle, then go to LOAD.
  - Reload the timeout counter.
- **LOAD**
  - Wait for `image_ready`=1, then go to REQ.
  - If the timeout counter reaches TIMEOUT-1 first, go to ERR.
- **REQ**
  - Drive `class_req`=1 with the current `class_idx`.
  - On `class_ack`:
    - For idx 0: load `best_score` and `best_idx` unconditionally.
    - Otherwise: replace them only if `class_score` > `best_score` (signed, strict). Ties keep the lower index.
  - Then:
    - If idx = NUM_CLASSES-1: go to DONE.
    - Otherwise: increment idx and go to GAP.
  - Timeout as in LOAD leads to ERR.
- **GAP**
  - Drive `class_req`=0 for one cycle, reload the timeout counter, return to REQ.
- **DONE**
  - `digit` <= `best_idx`; pulse `digit_valid`; go to IDLE.
- **ERR**
  - Set `error`=1; `digit` unchanged; no `digit_valid` pulse; go to IDLE.

Width and arithmetic rules:
- Comparison is signed over SCORE_W bits.
- The timeout counter is $clog2(TIMEOUT) bits and saturates; it does not wrap.

Boundary rules:
- `image_ready` and timeout in the same cycle: `image_ready` wins.
- `class_ack` and timeout in the same cycle: `class_ack` wins.
- `class_ack` outside REQ is ignored.
- `image_ready` already high in ARM (stale flag from the previous frame) is ignored. Only LOAD samples it, and by then the reader has been restarted.
- Asserting `reset_n` mid-operation forces IDLE immediately.
  - All outputs return to their reset values.
  - `best_score` and `best_idx` clear.
  - `error` clears.

## Timing
- `start` sampled at edge E0 → ARM for cycle E0–E1 (`rd_reset_n`=0) → LOAD from E1.
- The reader needs 29 cycles after `rd_reset_n` release, so `image_ready` is expected about 30 cycles after E1. TIMEOUT must exceed this.
- Per class: minimum 2 cycles (REQ + GAP) with a same-cycle ack.
- Minimum latency from `image_ready` sampled to `digit_valid`: 2·NUM_CLASSES cycles. The last REQ goes to DONE with no GAP, so that is REQ×10, GAP×9, then DONE = 20 cycles.
- `class_idx` and `class_req` are registered. `class_idx` is stable for the whole time `class_req` is high.
- `busy` falls in the same cycle as the `digit_valid` pulse, on the transition DONE→IDLE.

## Structure
- Package `mnist_pkg`:
  - state enum (IDLE, ARM, LOAD, REQ, GAP, DONE, ERR);
  - NUM_CLASSES;
  - DIGIT_W=4;
  - default SCORE_W.
- Sub-module `score_argmax`:
  - ports: `clk`, `reset_n`, `clear`, `load_en`, `first`, `idx`, `score`, `best_idx`.
  - holds the running maximum and applies the strict-greater/lower-index tie rule.
- FSM and timeout counter live in `mnist_infer_ctrl`.

## Test plan
- **Nominal:** start pulse; `image_ready` 30 cycles after ARM; same-cycle ack; scores 5,-3,7,100,2,0,-50,99,100,1 → `digit`=3 (tie with 8, lower index wins), one `digit_valid` pulse, `error`=0.
- **All negative:** scores -10,-9,…,-1 (class 9 = -1) → `digit`=9; signed compare verified.
- **Load timeout:** `image_ready` never asserts → `error`=1 exactly TIMEOUT cycles after LOAD entry, no `digit_valid`, `digit` keeps its previous value. The next start clears `error`.
- **Slow scorer:** ack delayed 5 cycles per class → `class_idx` stable while `class_req` is high, `class_req` low for exactly 1 cycle between classes, total REQ-to-DONE = 10·6+9 cycles.
- **Start while busy:** second `start` asserted during REQ → ignored, exactly one `digit_valid` pulse.
- **Mid-op reset:** `reset_n` low during class 4 → all outputs at reset values, `rd_reset_n`=1. A new start runs the full sequence from class 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST inference sequencer and its argmax helper.
// Pure declarations; no logic, no latency.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DIGIT_W     = 4;
    localparam int SCORE_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        REQ,
        GAP,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mnist_infer_ctrl_score_argmax.sv
// Running signed argmax over class scores; result visible the cycle after load_en.
// No backpressure: every load_en cycle is consumed.
module score_argmax
    import mnist_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = DIGIT_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      load_en,
    input  logic                      first,
    input  logic [IDX_W-1:0]          idx,
    input  logic signed [SCORE_W-1:0] score,
    output logic [IDX_W-1:0]          best_idx
);

    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;

    // Strict greater-than keeps the lower index on ties.
    always_comb begin
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        if (clear) begin
            best_score_d = '0;
            best_idx_d   = '0;
        end else if (load_en && (first || (score > best_score_q))) begin
            best_score_d = score;
            best_idx_d   = idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_score_q <= '0;
            best_idx_q   <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign best_idx = best_idx_q;

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Inference sequencer: restart reader, wait for image, score NUM_CLASSES classes, report argmax.
// All outputs registered; scorer stalls via late class_ack, each wait phase bounded by TIMEOUT.
module mnist_infer_ctrl #(
    parameter int SCORE_W     = mnist_pkg::SCORE_W_DEF,
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int TIMEOUT     = 64
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    output logic                              rd_reset_n,
    input  logic                              image_ready,
    output logic                              class_req,
    output logic [mnist_pkg::DIGIT_W-1:0]     class_idx,
    input  logic                              class_ack,
    input  logic signed [SCORE_W-1:0]         class_score,
    output logic [mnist_pkg::DIGIT_W-1:0]     digit,
    output logic                              digit_valid,
    output logic                              busy,
    output logic                              error
);
    import mnist_pkg::*;

    localparam int                 CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DIGIT_W-1:0] LAST_IDX = DIGIT_W'(NUM_CLASSES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_step;
    logic [DIGIT_W-1:0]   class_idx_q, class_idx_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic [DIGIT_W-1:0]   best_idx;
    logic                 rd_reset_n_q, rd_reset_n_d;
    logic                 class_req_q, class_req_d;
    logic                 digit_valid_q, digit_valid_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic                 argmax_clear, argmax_load, timed_out;

    assign cnt_step  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timed_out = (cnt_q == TMO_LAST);

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        class_idx_d   = class_idx_q;
        digit_d       = digit_q;
        error_d       = error_q;
        rd_reset_n_d  = 1'b1;
        digit_valid_d = 1'b0;
        argmax_clear  = 1'b0;
        argmax_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ARM;
                    error_d      = 1'b0;
                    class_idx_d  = '0;
                    argmax_clear = 1'b1;
                    rd_reset_n_d = 1'b0;
                end
            end
            ARM: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (image_ready) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_step;
                end
            end
            REQ: begin
                if (class_ack) begin
                    argmax_load = 1'b1;
                    if (class_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        class_idx_d = class_idx_q + DIGIT_W'(1);
                        state_d     = GAP;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_step;
                end
            end
            GAP: begin
                cnt_d   = '0;
                state_d = REQ;
            end
            DONE: begin
                digit_d       = best_idx;
                digit_valid_d = 1'b1;
                state_d       = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        class_req_d = (state_d == REQ);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            class_idx_q   <= '0;
            digit_q       <= '0;
            rd_reset_n_q  <= 1'b1;
            class_req_q   <= 1'b0;
            digit_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            class_idx_q   <= class_idx_d;
            digit_q       <= digit_d;
            rd_reset_n_q  <= rd_reset_n_d;
            class_req_q   <= class_req_d;
            digit_valid_q <= digit_valid_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    score_argmax #(
        .SCORE_W (SCORE_W),
        .IDX_W   (DIGIT_W)
    ) u_argmax (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (argmax_clear),
        .load_en  (argmax_load),
        .first    (class_idx_q == '0),
        .idx      (class_idx_q),
        .score    (class_score),
        .best_idx (best_idx)
    );

    assign rd_reset_n  = rd_reset_n_q;
    assign class_req   = class_req_q;
    assign class_idx   = class_idx_q;
    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Directed bench for mnist_infer_ctrl with a behavioural reader and scorer.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mnist_infer_ctrl;

    localparam int NC  = 10;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              image_ready = 1'b0;
    logic              class_ack = 1'b0;
    logic signed [11:0] class_score = '0;
    logic              rd_reset_n, class_req, digit_valid, busy, error;
    logic [3:0]        class_idx, digit;

    always #5 clk = ~clk;

    mnist_infer_ctrl #(
        .SCORE_W     (12),
        .NUM_CLASSES (NC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rd_reset_n  (rd_reset_n),
        .image_ready (image_ready),
        .class_req   (class_req),
        .class_idx   (class_idx),
        .class_ack   (class_ack),
        .class_score (class_score),
        .digit       (digit),
        .digit_valid (digit_valid),
        .busy        (busy),
        .error       (error)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int cur_sc[10];
    int ack_dly = 0;
    int rdy_dly = 30;
    logic start_in_req = 1'b0;

    int   dv_cnt, rd_low, reqs, first_idx, idx_unstable, gap_min, gap_max, low_run;
    int   wait_cnt, rd_cnt, t_arm, t_rdy, t_req0, t_dv, t_err;
    logic req_prev, rd_on, err_seen, dv_busy;
    logic [3:0] req_idx;

    int sc_nom[10]  = '{5, -3, 7, 100, 2, 0, -50, 99, 100, 1};
    int sc_neg[10]  = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
    int sc_slow[10] = '{10, -1, -2, -3, -4, -5, -6, -7, -8, -9};
    int sc_busy[10] = '{-2048, -2048, -2048, -2048, -2048, -2047, -2048, -2048, -2048, -2048};

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        dv_cnt = 0; rd_low = 0; reqs = 0; first_idx = -1; idx_unstable = 0;
        gap_min = 999; gap_max = 0; low_run = 0; wait_cnt = 0; rd_cnt = 0;
        t_arm = 0; t_rdy = 0; t_req0 = 0; t_dv = 0; t_err = 0;
        req_prev = 1'b0; rd_on = 1'b0; err_seen = 1'b0; dv_busy = 1'b1;
    endtask

    // One clock: observe DUT at the falling edge, then drive reader/scorer for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (digit_valid) begin
            dv_cnt++;
            t_dv    = cyc;
            dv_busy = busy;
        end
        if (error && !err_seen) begin
            err_seen = 1'b1;
            t_err    = cyc;
        end
        if (!rd_reset_n) begin
            rd_low++;
            t_arm       = cyc;
            image_ready = 1'b0;
            rd_cnt      = 0;
            rd_on       = 1'b1;
        end else if (rd_on) begin
            rd_cnt++;
            if (rd_cnt == rdy_dly) begin
                image_ready = 1'b1;
                t_rdy       = cyc;
                rd_on       = 1'b0;
            end
        end
        if (class_req) begin
            if (!req_prev) begin
                if (reqs == 0) begin
                    first_idx = int'(class_idx);
                    t_req0    = cyc;
                end else begin
                    if (low_run < gap_min) gap_min = low_run;
                    if (low_run > gap_max) gap_max = low_run;
                end
                reqs++;
                wait_cnt = 0;
                req_idx  = class_idx;
            end else if (class_idx != req_idx) begin
                idx_unstable++;
            end
            class_ack   = (wait_cnt == ack_dly);
            class_score = 12'(cur_sc[class_idx]);
            wait_cnt++;
            low_run = 0;
        end else begin
            class_ack = 1'b0;
            low_run++;
        end
        if (start_in_req) start = class_req && (class_idx == 4'd2);
        req_prev = class_req;
    endtask

    task automatic run_frame(input string nm, input int s[10], input int rdy, input int ackd,
                             input int exp_digit, input bit expect_err);
        int n;
        for (int i = 0; i < NC; i++) cur_sc[i] = s[i];
        rdy_dly = rdy;
        ack_dly = ackd;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, ":arm_rd_reset_n"}, int'(rd_reset_n), 0);
        check({nm, ":arm_busy"}, int'(busy), 1);
        check({nm, ":arm_error_clr"}, int'(error), 0);
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({nm, ":frame_ends_idle"}, int'(busy), 0);
        check({nm, ":rd_low_cycles"}, rd_low, 1);
        check({nm, ":digit"}, int'(digit), exp_digit);
        if (!expect_err) begin
            check({nm, ":dv_pulses"}, dv_cnt, 1);
            check({nm, ":busy_at_dv"}, int'(dv_busy), 0);
            check({nm, ":error"}, int'(error), 0);
            check({nm, ":requests"}, reqs, NC);
            check({nm, ":first_idx"}, first_idx, 0);
            check({nm, ":idx_unstable"}, idx_unstable, 0);
            check({nm, ":gap_min"}, gap_min, 1);
            check({nm, ":gap_max"}, gap_max, 1);
            check({nm, ":ready_to_req"}, t_req0 - t_rdy, 1);
            check({nm, ":req_to_dv"}, t_dv - t_req0, NC * (ackd + 1) + NC);
        end else begin
            check({nm, ":dv_pulses"}, dv_cnt, 0);
            check({nm, ":error"}, int'(error), 1);
            check({nm, ":error_seen"}, int'(err_seen), 1);
            check({nm, ":load_to_error"}, t_err - (t_arm + 1), TMO);
            check({nm, ":requests"}, reqs, 0);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ":rd_reset_n"}, int'(rd_reset_n), 1);
        check({nm, ":class_req"}, int'(class_req), 0);
        check({nm, ":class_idx"}, int'(class_idx), 0);
        check({nm, ":digit"}, int'(digit), 0);
        check({nm, ":digit_valid"}, int'(digit_valid), 0);
        check({nm, ":busy"}, int'(busy), 0);
        check({nm, ":error"}, int'(error), 0);
    endtask

    initial begin
        int n;
        clear_mon();
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        run_frame("nominal", sc_nom, 30, 0, 3, 1'b0);
        run_frame("all_neg", sc_neg, 30, 0, 9, 1'b0);
        run_frame("load_tmo", sc_nom, 1000, 0, 9, 1'b1);
        run_frame("slow", sc_slow, 30, 5, 0, 1'b0);

        start_in_req = 1'b1;
        run_frame("start_busy", sc_busy, 30, 2, 5, 1'b0);
        start_in_req = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("start_busy:no_requeue", int'(busy), 0);
        check("start_busy:dv_total", dv_cnt, 1);

        // Abort in the middle of class 4, then verify a clean full rerun.
        for (int i = 0; i < NC; i++) cur_sc[i] = sc_nom[i];
        rdy_dly = 30;
        ack_dly = 1;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(class_req && class_idx == 4'd4) && n < 200) begin
            tick();
            n++;
        end
        check("midrst:reached_class4", int'(class_idx), 4);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        tick();
        run_frame("after_rst", sc_nom, 30, 0, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
